// File: rtl/fcpu_pkg.sv
// Shared global-memory interface widths and elaboration-time helpers
// used across the compute-unit memory subsystem.
package fcpu_pkg;

    localparam int GMEM_ADDR_W = 32;
    localparam int GMEM_DATA_W = 32;
    localparam int ID_WIDTH    = 4;

    // Index width that never collapses to zero bits, even for a single-entry pool.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after last_grant,
// wrapping modulo N. Shared by the global-memory read and write paths.
module rr_arbiter
    import fcpu_pkg::*;
#(
    parameter int N = 4,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    logic [W-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand       = '0;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                cand = W'((int'(last_grant) + k) % N);
                if (!any && req[cand]) begin
                    gnt_onehot[cand] = 1'b1;
                    gnt_idx          = cand;
                    any              = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gmem_rd_arbiter.sv
// Shares the global-memory AXI read port between N_REQ requesters: round-robin AR
// issue through one register slot, in-order owner FIFO steering R beats back.
module gmem_rd_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int OWNER_FIFO_W = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_REQ-1:0][GMEM_ADDR_W-1:0]     req_araddr,
    input  logic [N_REQ-1:0][7:0]                 req_arlen,
    input  logic [N_REQ-1:0]                      req_arvalid,
    output logic [N_REQ-1:0]                      req_arready,
    output logic [GMEM_DATA_W-1:0]                req_rdata,
    output logic                                  req_rlast,
    output logic [N_REQ-1:0]                      req_rvalid,
    input  logic [N_REQ-1:0]                      req_rready,
    output logic [GMEM_ADDR_W-1:0]                m0_araddr,
    output logic [7:0]                            m0_arlen,
    output logic                                  m0_arvalid,
    input  logic                                  m0_arready,
    output logic [ID_WIDTH-1:0]                   m0_arid,
    input  logic [GMEM_DATA_W-1:0]                m0_rdata,
    input  logic                                  m0_rlast,
    input  logic                                  m0_rvalid,
    output logic                                  m0_rready,
    input  logic [ID_WIDTH-1:0]                   m0_rid,
    output logic [OWNER_FIFO_W:0]                 outstanding,
    output logic                                  protocol_err
);

    localparam int IDX_W = clog2_min1(N_REQ);
    localparam int DEPTH = 1 << OWNER_FIFO_W;
    localparam logic [OWNER_FIFO_W:0]   DEPTH_CNT = (OWNER_FIFO_W + 1)'(DEPTH);
    localparam logic [OWNER_FIFO_W-1:0] PTR_ONE   = OWNER_FIFO_W'(1);
    localparam logic [OWNER_FIFO_W:0]   CNT_ONE   = (OWNER_FIFO_W + 1)'(1);

    logic                      ar_valid_q, ar_valid_d;
    logic [GMEM_ADDR_W-1:0]    ar_addr_q,  ar_addr_d;
    logic [7:0]                ar_len_q,   ar_len_d;
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;
    logic [OWNER_FIFO_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OWNER_FIFO_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OWNER_FIFO_W:0]     outstanding_q, outstanding_d;
    logic                      err_q, err_d;
    logic [IDX_W-1:0]          owner_mem [DEPTH];

    logic                      slot_free;
    logic                      can_issue;
    logic                      fifo_empty;
    logic [IDX_W-1:0]          head;
    logic [N_REQ-1:0]          gnt_onehot;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      gnt_any;
    logic                      push;
    logic                      pop;

    assign slot_free  = !ar_valid_q || m0_arready;
    assign can_issue  = slot_free && (outstanding_q < DEPTH_CNT);
    assign fifo_empty = (outstanding_q == '0);
    assign head       = owner_mem[rd_ptr_q];

    // Grants are suppressed while reset is held so req_arready reads zero asynchronously.
    rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (req_arvalid),
        .en         (can_issue && !rst),
        .last_grant (last_grant_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign req_arready = gnt_onehot;
    assign push        = gnt_any;
    assign pop         = !fifo_empty && m0_rvalid && m0_rready && m0_rlast;

    assign m0_araddr    = ar_addr_q;
    assign m0_arlen     = ar_len_q;
    assign m0_arvalid   = ar_valid_q;
    assign m0_arid      = '0;
    assign outstanding  = outstanding_q;
    assign protocol_err = err_q;

    assign req_rdata = m0_rdata;
    assign req_rlast = m0_rlast;

    always_comb begin
        req_rvalid = '0;
        m0_rready  = 1'b0;
        if (!fifo_empty) begin
            m0_rready        = req_rready[head];
            req_rvalid[head] = m0_rvalid;
        end
    end

    always_comb begin
        ar_valid_d   = ar_valid_q;
        ar_addr_d    = ar_addr_q;
        ar_len_d     = ar_len_q;
        last_grant_d = last_grant_q;
        if (gnt_any) begin
            ar_valid_d   = 1'b1;
            ar_addr_d    = req_araddr[gnt_idx];
            ar_len_d     = req_arlen[gnt_idx];
            last_grant_d = gnt_idx;
        end else if (m0_arready) begin
            ar_valid_d = 1'b0;
        end
    end

    // The FIFO admits a push only below full, independent of a same-cycle pop.
    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        outstanding_d = outstanding_q;
        case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
        err_d = err_q || (m0_rvalid && (fifo_empty || (m0_rid != '0)));
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_valid_q    <= 1'b0;
            ar_addr_q     <= '0;
            ar_len_q      <= '0;
            last_grant_q  <= IDX_W'(N_REQ - 1);
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            ar_valid_q    <= ar_valid_d;
            ar_addr_q     <= ar_addr_d;
            ar_len_q      <= ar_len_d;
            last_grant_q  <= last_grant_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // NOTE: the owner storage has no reset; entries are only read between a push
    // and its pop, and outstanding (which is reset) decides emptiness.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_mem[wr_ptr_q] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_gmem_rd_arbiter.sv
// Directed bench for gmem_rd_arbiter: a cycle table for arbitration/full/routing,
// then hand-written sequences for bursts, backpressure, errors and async reset.
module tb_gmem_rd_arbiter;
    import fcpu_pkg::*;

    localparam int N = 4;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [N-1:0][GMEM_ADDR_W-1:0]     req_araddr;
    logic [N-1:0][7:0]                 req_arlen;
    logic [N-1:0]                      req_arvalid;
    logic [N-1:0]                      req_arready;
    logic [GMEM_DATA_W-1:0]            req_rdata;
    logic                              req_rlast;
    logic [N-1:0]                      req_rvalid;
    logic [N-1:0]                      req_rready;
    logic [GMEM_ADDR_W-1:0]            m0_araddr;
    logic [7:0]                        m0_arlen;
    logic                              m0_arvalid;
    logic                              m0_arready;
    logic [ID_WIDTH-1:0]               m0_arid;
    logic [GMEM_DATA_W-1:0]            m0_rdata;
    logic                              m0_rlast;
    logic                              m0_rvalid;
    logic                              m0_rready;
    logic [ID_WIDTH-1:0]               m0_rid;
    logic [2:0]                        outstanding;
    logic                              protocol_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gmem_rd_arbiter #(.N_REQ(N), .OWNER_FIFO_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_araddr   (req_araddr),
        .req_arlen    (req_arlen),
        .req_arvalid  (req_arvalid),
        .req_arready  (req_arready),
        .req_rdata    (req_rdata),
        .req_rlast    (req_rlast),
        .req_rvalid   (req_rvalid),
        .req_rready   (req_rready),
        .m0_araddr    (m0_araddr),
        .m0_arlen     (m0_arlen),
        .m0_arvalid   (m0_arvalid),
        .m0_arready   (m0_arready),
        .m0_arid      (m0_arid),
        .m0_rdata     (m0_rdata),
        .m0_rlast     (m0_rlast),
        .m0_rvalid    (m0_rvalid),
        .m0_rready    (m0_rready),
        .m0_rid       (m0_rid),
        .outstanding  (outstanding),
        .protocol_err (protocol_err)
    );

    typedef struct {
        logic [3:0] arv;
        logic       m_arready;
        logic       m_rvalid;
        logic       m_rlast;
        logic [3:0] rrdy;
        logic [3:0] e_arready;
        logic       e_arvalid;
        logic [2:0] e_out;
        logic [3:0] e_rvalid;
        logic       e_rready;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_araddr  = '0;
        req_arlen   = '0;
        req_arvalid = '0;
        req_rready  = '0;
        m0_arready  = 1'b0;
        m0_rdata    = '0;
        m0_rlast    = 1'b0;
        m0_rvalid   = 1'b0;
        m0_rid      = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".m0_arvalid"},   64'(m0_arvalid),   64'd0);
        check({tag, ".req_arready"},  64'(req_arready),  64'd0);
        check({tag, ".req_rvalid"},   64'(req_rvalid),   64'd0);
        check({tag, ".m0_rready"},    64'(m0_rready),    64'd0);
        check({tag, ".outstanding"},  64'(outstanding),  64'd0);
        check({tag, ".protocol_err"}, 64'(protocol_err), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int c;
        logic [GMEM_DATA_W-1:0] got[$];
        logic [3:0] exp_owner[4];

        rst = 1'b1;
        idle_inputs();

        // arv, arready, rvalid, rlast, rrdy | e_arready, e_arvalid, e_out, e_rvalid, e_rready
        vecs[0]  = '{4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0001, 1'b0, 3'd0, 4'b0000, 1'b0};
        vecs[1]  = '{4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0010, 1'b1, 3'd1, 4'b0000, 1'b0};
        vecs[2]  = '{4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0100, 1'b1, 3'd2, 4'b0000, 1'b0};
        vecs[3]  = '{4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 1'b1, 3'd3, 4'b0000, 1'b0};
        vecs[4]  = '{4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b1, 3'd4, 4'b0000, 1'b0};
        vecs[5]  = '{4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 3'd4, 4'b0000, 1'b0};
        vecs[6]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 3'd4, 4'b0001, 1'b1};
        vecs[7]  = '{4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 4'b0001, 1'b0, 3'd3, 4'b0000, 1'b1};
        vecs[8]  = '{4'hF, 1'b1, 1'b1, 1'b0, 4'hF, 4'b0000, 1'b1, 3'd4, 4'b0010, 1'b1};
        vecs[9]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'hD, 4'b0000, 1'b0, 3'd4, 4'b0010, 1'b0};
        vecs[10] = '{4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 3'd4, 4'b0010, 1'b1};
        vecs[11] = '{4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'b0000, 1'b0, 3'd3, 4'b0000, 1'b1};

        // Round-robin order, full stall (including a pop while full), routing, backpressure.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req_arvalid = vecs[i].arv;
            m0_arready  = vecs[i].m_arready;
            m0_rvalid   = vecs[i].m_rvalid;
            m0_rlast    = vecs[i].m_rlast;
            req_rready  = vecs[i].rrdy;
            m0_rdata    = GMEM_DATA_W'(32'h1000 + i);
            @(negedge clk);
            check($sformatf("vec%0d.req_arready", i), 64'(req_arready), 64'(vecs[i].e_arready));
            check($sformatf("vec%0d.m0_arvalid", i),  64'(m0_arvalid),  64'(vecs[i].e_arvalid));
            check($sformatf("vec%0d.outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
            check($sformatf("vec%0d.req_rvalid", i),  64'(req_rvalid),  64'(vecs[i].e_rvalid));
            check($sformatf("vec%0d.m0_rready", i),   64'(m0_rready),   64'(vecs[i].e_rready));
            tick();
        end

        // Single requester, 4-beat burst.
        do_reset();
        req_arvalid   = 4'b0010;
        req_araddr[1] = 32'h1000_0040;
        req_arlen[1]  = 8'd3;
        @(negedge clk);
        check("single.grant", 64'(req_arready), 64'b0010);
        check("single.arvalid_before", 64'(m0_arvalid), 64'd0);
        tick();
        req_arvalid = '0;
        m0_arready  = 1'b1;
        @(negedge clk);
        check("single.arvalid", 64'(m0_arvalid), 64'd1);
        check("single.araddr", 64'(m0_araddr), 64'h1000_0040);
        check("single.arlen", 64'(m0_arlen), 64'd3);
        check("single.arid", 64'(m0_arid), 64'd0);
        check("single.out1", 64'(outstanding), 64'd1);
        tick();
        m0_arready = 1'b0;
        req_rready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            m0_rvalid = 1'b1;
            m0_rdata  = GMEM_DATA_W'(32'hA0 + k);
            m0_rlast  = (k == 3);
            @(negedge clk);
            check($sformatf("single.b%0d.rvalid", k), 64'(req_rvalid), 64'b0010);
            check($sformatf("single.b%0d.rdata", k), 64'(req_rdata), 64'(32'hA0 + k));
            check($sformatf("single.b%0d.rlast", k), 64'(req_rlast), 64'(k == 3));
            check($sformatf("single.b%0d.m0_rready", k), 64'(m0_rready), 64'd1);
            tick();
        end
        m0_rvalid = 1'b0;
        m0_rlast  = 1'b0;
        @(negedge clk);
        check("single.out0", 64'(outstanding), 64'd0);
        check("single.arvalid_done", 64'(m0_arvalid), 64'd0);
        tick();

        // Requester 2 then 0, two beats each, returned in issue order.
        do_reset();
        req_arvalid   = 4'b0100;
        req_araddr[2] = 32'h0000_2000;
        req_arlen[2]  = 8'd1;
        @(negedge clk);
        check("order.grant2", 64'(req_arready), 64'b0100);
        tick();
        req_arvalid   = 4'b0001;
        req_araddr[0] = 32'h0000_3000;
        req_arlen[0]  = 8'd1;
        m0_arready    = 1'b1;
        @(negedge clk);
        check("order.grant0_b2b", 64'(req_arready), 64'b0001);
        check("order.addr2", 64'(m0_araddr), 64'h2000);
        tick();
        req_arvalid = '0;
        @(negedge clk);
        check("order.addr0", 64'(m0_araddr), 64'h3000);
        check("order.out2", 64'(outstanding), 64'd2);
        tick();
        m0_arready   = 1'b0;
        req_rready   = 4'hF;
        exp_owner[0] = 4'b0100;
        exp_owner[1] = 4'b0100;
        exp_owner[2] = 4'b0001;
        exp_owner[3] = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            m0_rvalid = 1'b1;
            m0_rdata  = GMEM_DATA_W'(32'hB0 + k);
            m0_rlast  = (k == 1) || (k == 3);
            @(negedge clk);
            check($sformatf("order.b%0d.rvalid", k), 64'(req_rvalid), 64'(exp_owner[k]));
            tick();
        end
        m0_rvalid = 1'b0;
        m0_rlast  = 1'b0;
        @(negedge clk);
        check("order.out0", 64'(outstanding), 64'd0);
        tick();

        // Backpressure: requester 3 stalls for 5 cycles mid-burst.
        do_reset();
        req_arvalid   = 4'b1000;
        req_araddr[3] = 32'h0000_4000;
        req_arlen[3]  = 8'd3;
        m0_arready    = 1'b1;
        tick();
        req_arvalid = '0;
        tick();
        m0_arready = 1'b0;
        b = 0;
        c = 0;
        while (b < 4 && c < 20) begin
            req_rready = (c >= 1 && c <= 5) ? 4'b0111 : 4'b1111;
            m0_rvalid  = 1'b1;
            m0_rdata   = GMEM_DATA_W'(32'hD0 + b);
            m0_rlast   = (b == 3);
            @(negedge clk);
            check($sformatf("bp.c%0d.m0_rready", c), 64'(m0_rready), 64'(!(c >= 1 && c <= 5)));
            check($sformatf("bp.c%0d.rvalid", c), 64'(req_rvalid), 64'b1000);
            if (m0_rready && req_rvalid[3]) begin
                got.push_back(req_rdata);
                b++;
            end
            tick();
            c++;
        end
        m0_rvalid = 1'b0;
        m0_rlast  = 1'b0;
        check("bp.beats", 64'(got.size()), 64'd4);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("bp.data%0d", k), 64'(got[k]), 64'(32'hD0 + k));
        end
        @(negedge clk);
        check("bp.out0", 64'(outstanding), 64'd0);
        tick();

        // Beat with nothing outstanding.
        do_reset();
        m0_rvalid  = 1'b1;
        m0_rlast   = 1'b1;
        req_rready = 4'hF;
        @(negedge clk);
        check("err_empty.m0_rready", 64'(m0_rready), 64'd0);
        check("err_empty.rvalid", 64'(req_rvalid), 64'd0);
        tick();
        m0_rvalid = 1'b0;
        m0_rlast  = 1'b0;
        @(negedge clk);
        check("err_empty.flag", 64'(protocol_err), 64'd1);
        tick();
        tick();
        @(negedge clk);
        check("err_empty.sticky", 64'(protocol_err), 64'd1);

        // Beat carrying a non-zero rid.
        do_reset();
        req_arvalid = 4'b0001;
        m0_arready  = 1'b1;
        tick();
        req_arvalid = '0;
        tick();
        m0_rvalid  = 1'b1;
        m0_rlast   = 1'b1;
        m0_rid     = 4'd1;
        req_rready = 4'hF;
        @(negedge clk);
        check("err_rid.clear_before", 64'(protocol_err), 64'd0);
        tick();
        m0_rvalid = 1'b0;
        m0_rid    = '0;
        @(negedge clk);
        check("err_rid.flag", 64'(protocol_err), 64'd1);
        tick();

        // Asynchronous reset with two bursts outstanding, then fresh arbitration.
        do_reset();
        req_arvalid   = 4'b0010;
        req_araddr[1] = 32'h0000_5000;
        req_arlen[1]  = 8'd3;
        m0_arready    = 1'b1;
        tick();
        req_arvalid   = 4'b0100;
        req_araddr[2] = 32'h0000_6000;
        req_arlen[2]  = 8'd3;
        tick();
        req_arvalid = '0;
        m0_arready  = 1'b0;
        m0_rvalid   = 1'b1;
        m0_rdata    = 32'hE0;
        req_rready  = 4'hF;
        @(negedge clk);
        check("arst.out2", 64'(outstanding), 64'd2);
        check("arst.arvalid", 64'(m0_arvalid), 64'd1);
        check("arst.rvalid", 64'(req_rvalid), 64'b0010);
        req_arvalid = 4'hF;
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        m0_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst.fresh_grant", 64'(req_arready), 64'b0001);
        tick();
        req_arvalid = '0;
        @(negedge clk);
        check("arst.out_after", 64'(outstanding), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmem_rd_arbiter.md
Name: gmem_rd_arbiter

Overview:
- Shares the single AXI read port (m0_ar*/m0_r*) of the global memory between N_REQ requesters, such as compute-unit load units or the instruction fetcher.
- Arbitrates AR requests round-robin, issues them to memory with arid = '0, and records the owner of each issued burst in an in-order owner FIFO.
- Routes R beats back to the owning requester.
- Sits between the requesters and global_mem; global_mem returns bursts in issue order and accepts only arid 0.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- OWNER_FIFO_W, 2, log2 of owner-FIFO depth, i.e. the maximum number of bursts outstanding at memory.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active high.
- req_araddr  in  N_REQ×GMEM_ADDR_W  per-requester burst address.
- req_arlen  in  N_REQ×8  per-requester AXI length (beats-1).
- req_arvalid  in  N_REQ  per-requester address valid.
- req_arready  out  N_REQ  one-hot grant/accept.
- req_rdata  out  GMEM_DATA_W  read data, broadcast to all requesters.
- req_rlast  out  1  last beat, broadcast.
- req_rvalid  out  N_REQ  one-hot beat valid, owner only.
- req_rready  in  N_REQ  per-requester beat ready.
- m0_araddr  out  GMEM_ADDR_W  to memory.
- m0_arlen  out  8  to memory.
- m0_arvalid  out  1  to memory.
- m0_arready  in  1  from memory.
- m0_arid  out  ID_WIDTH  tied '0.
- m0_rdata  in  GMEM_DATA_W  from memory.
- m0_rlast  in  1  from memory.
- m0_rvalid  in  1  from memory.
- m0_rready  out  1  to memory.
- m0_rid  in  ID_WIDTH  from memory; checked only.
- outstanding  out  OWNER_FIFO_W+1  bursts issued and not yet completed.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst=1) clears the following to zero: m0_arvalid, req_arready, req_rvalid, m0_rready, outstanding, protocol_err, owner FIFO pointers, and the round-robin pointer (last_grant = N_REQ-1). In-flight bursts are discarded; global_mem must be reset together with this block.
- AR slot:
  - A single register stage holds addr, len and valid.
  - slot_free = !m0_arvalid || m0_arready.
  - can_issue = slot_free && (outstanding < 2**OWNER_FIFO_W).
- Arbitration (combinational, in sub-module):
  - When can_issue, grant the first asserted req_arvalid searching from last_grant+1 upward, wrapping mod N_REQ.
  - req_arready[g] = 1 in that same cycle only; it is zero otherwise.
  - No requester waits more than N_REQ-1 grants.
- Capture on the grant edge:
  - m0_araddr/m0_arlen ← req_araddr[g]/req_arlen[g]; m0_arvalid ← 1; push g into the owner FIFO; last_grant ← g.
  - m0_arvalid stays high with stable fields until m0_arready. Back-to-back issue is allowed: accept and re-grant in the same cycle, so 1 request per cycle throughput.
  - Latency: requester accept to m0_arvalid is 1 cycle.
- The owner FIFO is pushed at grant, not at m0_arready, so ownership order equals issue order.
- R routing:
  - head = owner FIFO head.
  - When the FIFO is non-empty: m0_rready = req_rready[head]; req_rvalid[head] = m0_rvalid; all other req_rvalid bits are 0; req_rdata = m0_rdata; req_rlast = m0_rlast. The path is purely combinational, adding 0 cycles.
  - On an m0_rvalid && m0_rready && m0_rlast handshake, pop the FIFO.
  - When the FIFO is empty: m0_rready = 0 and all req_rvalid = 0.
- outstanding:
  - Increments on push and decrements on pop.
  - Simultaneous push and pop leaves it unchanged.
  - Push is gated only by the count, not by a pop in the same cycle, so full blocks grant even if a pop occurs in that cycle.
- Pointers are OWNER_FIFO_W bits wide and wrap naturally; full/empty are decided from outstanding.
- protocol_err is set, and stays set until reset, on either condition:
  - m0_rvalid while the FIFO is empty;
  - m0_rvalid with m0_rid ≠ 0.
  In the empty-FIFO case the beat is not accepted.
- A requester holding req_arvalid with changing address before acceptance is permitted; the value sampled is the one present in the grant cycle.

Decomposition:
- fcpu_pkg supplies GMEM_ADDR_W, GMEM_DATA_W and ID_WIDTH.
- Add function clog2_min1 to fcpu_pkg for the owner index width: max(1, $clog2(N_REQ)).
- One sub-module, rr_arbiter:
  - params N;
  - inputs req[N], en, last_grant;
  - outputs gnt_onehot[N], gnt_idx, any.
  - Purely combinational, reusable for the write-side arbiter.

Test Plan:
- Single requester: req 1 issues addr 0x10000040, arlen 3 → m0_arvalid 1 cycle after req_arready[1]. 4 beats route to req_rvalid[1] only, req_rlast on beat 4, outstanding goes 1→0.
- All 4 requesters asserting continuously, m0_arready=1 → grant order 0,1,2,3,0,… with one grant per cycle until outstanding=4, then grants stall until the first rlast.
- Requesters 2 and 0 each issue arlen=1 → beats returned in issue order: 2 beats to requester 2, then 2 to requester 0; no req_rvalid overlap.
- Backpressure: req_rready[3]=0 for 5 cycles mid-burst → m0_rready=0 for those cycles, no beat lost or duplicated, data order preserved.
- Error injection: m0_rvalid=1 with empty FIFO → protocol_err=1 and stays 1. Separately, m0_rid=1 → protocol_err=1.
- rst asserted mid-burst with outstanding=2 → all outputs 0 immediately (asynchronously). After release, a fresh request is granted starting at requester 0.
